// File: rtl/alarm_clock_fsm.sv
// ---------------------------------------------------------------------------
// alarm_clock_fsm
//
// Control state machine for the digital alarm clock. Interprets keypad
// digits, the alarm button and the time button, and sequences the shared
// display / register datapath. A keypad-entry timeout returns the display
// to the running time when the user stops typing.
//
// Ports:
//   clock          in   system clock, all state changes on the rising edge
//   reset          in   synchronous, active-high
//   one_second     in   one-clock-wide pulse, once per second
//   key [3:0]      in   keypad code (0-9 digits, anything else = no key)
//   alarm_button   in   level, high while pressed
//   time_button    in   level, high while pressed
//   show_alarm     out  display selects the alarm register
//   show_new_time  out  display selects the key-entry register
//   shift          out  one-cycle strobe, shifts key into key-entry register
//   load_new_a     out  one-cycle strobe, loads alarm register
//   load_new_c     out  one-cycle strobe, loads current-time register
//   digit_count[2:0] out digits captured in the current entry, 0-4
// ---------------------------------------------------------------------------
module alarm_clock_fsm #(
    parameter logic [3:0] NOKEY       = 4'd10,
    parameter logic [3:0] TIMEOUT_SEC = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic [2:0] digit_count
);

    localparam logic [2:0] SHOW_TIME  = 3'd0;
    localparam logic [2:0] SHOW_ALARM = 3'd1;
    localparam logic [2:0] KEY_STORED = 3'd2;
    localparam logic [2:0] KEY_WAITED = 3'd3;
    localparam logic [2:0] KEY_ENTRY  = 3'd4;
    localparam logic [2:0] SET_ALARM  = 3'd5;
    localparam logic [2:0] SET_TIME   = 3'd6;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] sec_cnt;
    logic       valid_key;
    logic       timeout;

    // Digits are the codes below NOKEY; codes NOKEY..15 all count as no key.
    assign valid_key = (key < NOKEY);
    assign timeout   = (sec_cnt == TIMEOUT_SEC);

    // Next-state logic. Buttons take priority over a timeout arriving on the
    // same cycle, and alarm beats time when both are pressed together.
    always_comb begin
        next_state = state;
        case (state)
            SHOW_TIME: begin
                if (alarm_button)
                    next_state = SHOW_ALARM;
                else if (valid_key)
                    next_state = KEY_STORED;
            end
            SHOW_ALARM: begin
                if (!alarm_button)
                    next_state = SHOW_TIME;
            end
            KEY_STORED: next_state = KEY_WAITED;
            KEY_WAITED: begin
                if (!valid_key)
                    next_state = KEY_ENTRY;
                else if (timeout)
                    next_state = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)
                    next_state = SET_ALARM;
                else if (time_button)
                    next_state = SET_TIME;
                else if (timeout)
                    next_state = SHOW_TIME;
                else if (valid_key && (digit_count < 3'd4))
                    next_state = KEY_STORED;
            end
            SET_ALARM: next_state = SHOW_TIME;
            SET_TIME:  next_state = SHOW_TIME;
            default:   next_state = SHOW_TIME;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= SHOW_TIME;
        else
            state <= next_state;
    end

    // Inactivity counter: only runs while waiting for the next key, and is
    // cleared whenever a digit is accepted so each digit restarts the window.
    // A one_second pulse landing in KEY_STORED is deliberately dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            sec_cnt <= 4'd0;
        end else if ((state == KEY_WAITED) || (state == KEY_ENTRY)) begin
            if (one_second && (sec_cnt != TIMEOUT_SEC))
                sec_cnt <= sec_cnt + 4'd1;
        end else begin
            sec_cnt <= 4'd0;
        end
    end

    // Digit counter: cleared while idle, bumped once per accepted digit and
    // held through the load states so it is still visible during the strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_count <= 3'd0;
        end else if ((state == SHOW_TIME) || (state == SHOW_ALARM)) begin
            digit_count <= 3'd0;
        end else if ((state == KEY_STORED) && (digit_count != 3'd4)) begin
            digit_count <= digit_count + 3'd1;
        end
    end

    // Moore output decode from the state register only.
    assign show_alarm    = (state == SHOW_ALARM);
    assign show_new_time = (state == KEY_STORED) || (state == KEY_WAITED) ||
                           (state == KEY_ENTRY)  || (state == SET_ALARM)  ||
                           (state == SET_TIME);
    assign shift         = (state == KEY_STORED);
    assign load_new_a    = (state == SET_ALARM);
    assign load_new_c    = (state == SET_TIME);

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// ---------------------------------------------------------------------------
// tb_alarm_clock_fsm
//
// Directed testbench for alarm_clock_fsm. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, so every sample
// reflects the state entered on the edge that consumed the previous inputs.
// Output bundle order: {show_alarm, show_new_time, shift, load_new_a,
// load_new_c}.
// ---------------------------------------------------------------------------
module tb_alarm_clock_fsm;

    localparam logic [3:0] NOKEY = 4'd10;

    localparam int O_IDLE   = 5'b00000;
    localparam int O_ALARM  = 5'b10000;
    localparam int O_STORED = 5'b01100;
    localparam int O_ENTRY  = 5'b01000;
    localparam int O_SETA   = 5'b01010;
    localparam int O_SETC   = 5'b01001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key = NOKEY;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       show_alarm;
    logic       show_new_time;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic [2:0] digit_count;

    int checkCount = 0;
    int failCount  = 0;
    int shiftCount = 0;
    int loadACount = 0;
    int loadCCount = 0;

    alarm_clock_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .show_alarm    (show_alarm),
        .show_new_time (show_new_time),
        .shift         (shift),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .digit_count   (digit_count)
    );

    always #5 clock = ~clock;

    function automatic int outs();
        return int'({show_alarm, show_new_time, shift, load_new_a, load_new_c});
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and tally strobes seen in the new cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        if (shift === 1'b1)      shiftCount++;
        if (load_new_a === 1'b1) loadACount++;
        if (load_new_c === 1'b1) loadCCount++;
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic ab, input logic tb, input logic os);
        key          = k;
        alarm_button = ab;
        time_button  = tb;
        one_second   = os;
        tick();
    endtask

    // Press a digit for 3 cycles, then release for 2 (ends in KEY_ENTRY).
    task automatic pressDigit(input logic [3:0] d);
        for (int i = 0; i < 3; i++) applyStimulus(d, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        shiftCount = 0;
        loadACount = 0;
        loadCCount = 0;
    endtask

    task automatic pulseSeconds(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1);
            applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int anyActive;

        // Reset and idle
        doReset();
        checkOutput("reset_outs", outs(), O_IDLE);
        checkOutput("reset_count", int'(digit_count), 0);
        anyActive = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
            if (outs() != 0 || digit_count != 3'd0) anyActive++;
        end
        checkOutput("idle_quiet", anyActive, 0);

        // Enter 1,2,3,4 then time_button; first digit checked cycle by cycle
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("d1_stored", outs(), O_STORED);
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("d1_waited", outs(), O_ENTRY);
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("d1_held_noshift", outs(), O_ENTRY);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("d1_count", int'(digit_count), 1);
        applyStimulus(4'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("d2_stored", outs(), O_STORED);
        for (int i = 0; i < 2; i++) applyStimulus(4'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        pressDigit(4'd3);
        pressDigit(4'd4);
        checkOutput("seq4_count", int'(digit_count), 4);
        applyStimulus(NOKEY, 1'b0, 1'b1, 1'b0);
        checkOutput("settime_outs", outs(), O_SETC);
        checkOutput("settime_count", int'(digit_count), 4);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("after_settime", outs(), O_IDLE);
        checkOutput("seq4_shifts", shiftCount, 4);
        checkOutput("seq4_loadc", loadCCount, 1);

        // Enter 0,7 then both buttons; alarm wins, keep holding alarm
        doReset();
        pressDigit(4'd0);
        pressDigit(4'd7);
        applyStimulus(NOKEY, 1'b1, 1'b1, 1'b0);
        checkOutput("both_seta", outs(), O_SETA);
        checkOutput("both_count", int'(digit_count), 2);
        applyStimulus(NOKEY, 1'b1, 1'b0, 1'b0);
        checkOutput("seta_home", outs(), O_IDLE);
        applyStimulus(NOKEY, 1'b1, 1'b0, 1'b0);
        checkOutput("show_alarm_1", outs(), O_ALARM);
        applyStimulus(NOKEY, 1'b1, 1'b0, 1'b0);
        applyStimulus(NOKEY, 1'b1, 1'b0, 1'b0);
        checkOutput("show_alarm_3", outs(), O_ALARM);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("alarm_release", outs(), O_IDLE);
        checkOutput("both_loada", loadACount, 1);
        checkOutput("both_loadc", loadCCount, 0);

        // Timeout after 10 idle seconds
        doReset();
        pressDigit(4'd5);
        pulseSeconds(9);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1);
        checkOutput("to_edge_entry", outs(), O_ENTRY);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("to_home", outs(), O_IDLE);
        checkOutput("to_noload", loadACount + loadCCount, 0);

        // A digit after the 9th second restarts the window
        doReset();
        pressDigit(4'd5);
        pulseSeconds(9);
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_stored", outs(), O_STORED);
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_count", int'(digit_count), 2);
        pulseSeconds(9);
        for (int i = 0; i < 4; i++) applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_alive", outs(), O_ENTRY);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_timeout", outs(), O_IDLE);

        // Button beats a timeout on the same cycle
        doReset();
        pressDigit(4'd8);
        pulseSeconds(9);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1);
        applyStimulus(NOKEY, 1'b0, 1'b1, 1'b0);
        checkOutput("btn_beats_to", outs(), O_SETC);

        // Five digits: the fifth is ignored
        doReset();
        for (int d = 1; d <= 5; d++) pressDigit(4'(d));
        checkOutput("five_shifts", shiftCount, 4);
        checkOutput("five_count", int'(digit_count), 4);
        checkOutput("five_entry", outs(), O_ENTRY);

        // Non-digit code in SHOW_TIME
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(4'd12, 1'b0, 1'b0, 1'b0);
        checkOutput("key12_outs", outs(), O_IDLE);
        checkOutput("key12_shifts", shiftCount, 0);

        // Reset mid-entry discards the entry
        doReset();
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_count_pre", int'(digit_count), 1);
        doReset();
        checkOutput("mid_reset_outs", outs(), O_IDLE);
        checkOutput("mid_reset_count", int'(digit_count), 0);
        for (int i = 0; i < 3; i++) applyStimulus(NOKEY, 1'b0, 1'b1, 1'b0);
        applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_no_load", loadACount + loadCCount, 0);
        checkOutput("mid_outs", outs(), O_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
